// File: rtl/oled_seq.sv
//------------------------------------------------------------------------------
// Module  : oled_seq
// Brief   : SSD1306 init + framebuffer refresh sequencer feeding an I2C byte master
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module oled_seq #(
    parameter logic [6:0] I2C_ADDR = 7'h3C,
    parameter int         N_INIT   = 25,
    parameter int         N_PIX    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [9:0] pix_addr,
    input  logic [7:0] pix_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_first,
    output logic       tx_last,
    input  logic       nack
);

    localparam logic [7:0]  c_ADDR_W   = {I2C_ADDR, 1'b0};
    localparam logic [7:0]  c_CTRL_CMD = 8'h00;
    localparam logic [7:0]  c_CTRL_DAT = 8'h40;
    localparam logic [4:0]  c_ROM_LAST = 5'(N_INIT - 1);
    localparam logic [10:0] c_PIX_LAST = 11'(N_PIX - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        I_ADDR  = 4'd1,
        I_CTRL  = 4'd2,
        I_CMD   = 4'd3,
        F_ADDR  = 4'd4,
        F_CTRL  = 4'd5,
        F_FETCH = 4'd6,
        F_DATA  = 4'd7,
        DONE    = 4'd8,
        ERR     = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_rom;
    logic [10:0] r_cnt;
    logic        r_init_done;
    logic        r_error;
    logic        w_rom_last;
    logic        w_pix_last;

    assign w_rom_last = (r_rom == c_ROM_LAST);
    assign w_pix_last = (r_cnt == c_PIX_LAST);
    assign busy       = (r_state != IDLE) && (r_state != ERR);
    assign error      = r_error;
    assign rom_addr   = r_rom;
    assign pix_addr   = r_cnt[9:0];

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        w_next   = r_state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_first = 1'b0;
        tx_last  = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = r_init_done ? F_ADDR : I_ADDR;
            end
            I_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = c_ADDR_W;
                tx_first = 1'b1;
                if (tx_ready) w_next = I_CTRL;
            end
            I_CTRL: begin
                tx_valid = 1'b1;
                tx_data  = c_CTRL_CMD;
                if (tx_ready) w_next = I_CMD;
            end
            I_CMD: begin
                tx_valid = 1'b1;
                tx_data  = rom_data;
                tx_last  = w_rom_last;
                if (tx_ready) w_next = w_rom_last ? F_ADDR : I_CMD;
            end
            F_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = c_ADDR_W;
                tx_first = 1'b1;
                if (tx_ready) w_next = F_CTRL;
            end
            F_CTRL: begin
                tx_valid = 1'b1;
                tx_data  = c_CTRL_DAT;
                if (tx_ready) w_next = F_FETCH;
            end
            F_FETCH: begin
                w_next = F_DATA;
            end
            F_DATA: begin
                tx_valid = 1'b1;
                tx_data  = pix_data;
                tx_last  = w_pix_last;
                if (tx_ready) w_next = w_pix_last ? DONE : F_FETCH;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (busy && nack) w_next = ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rom       <= 5'd0;
            r_cnt       <= 11'd0;
            r_init_done <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_error <= 1'b0;
                r_rom   <= 5'd0;
                r_cnt   <= 11'd0;
            end
            // A NACK wins over a coincident accept: nothing advances.
            if (busy && nack) begin
                r_error <= 1'b1;
            end else if (tx_ready) begin
                if (r_state == I_CMD) begin
                    if (w_rom_last) r_init_done <= 1'b1;
                    else            r_rom       <= r_rom + 5'd1;
                end
                if (r_state == F_DATA) begin
                    r_cnt <= w_pix_last ? 11'd0 : r_cnt + 11'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_oled_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_oled_seq
// Brief   : randomized bench for oled_seq against an expected-byte-stream model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_oled_seq;

    localparam int N_INIT = 25;
    localparam int N_PIX  = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tx_ready = 1'b1;
    logic       nack = 1'b0;
    logic       busy, done, error, tx_valid, tx_first, tx_last;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [9:0] pix_addr;
    logic [7:0] pix_data = 8'h00;
    logic [7:0] tx_data;

    logic [7:0] rom [32];
    logic [7:0] fb  [N_PIX];

    // tag: 0 plain, 1 frame control byte 0x40, 2 init command 3, 3 last init command
    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
        int         tag;
    } item_t;

    item_t q[$];
    item_t it;

    int  tests = 0;
    int  fails = 0;
    bit  m_init_done = 1'b0;
    int  run_bytes = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  stall40 = 0;
    int  stall_cnt = 0;
    bit  stall_arm = 1'b0;
    bit  nack_arm = 1'b0;
    bit  rand_ready = 1'b0;
    bit  err_chk = 1'b0;
    bit  hold_chk = 1'b0;
    logic [9:0] held;

    oled_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pix_addr (pix_addr),
        .pix_data (pix_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_first (tx_first),
        .tx_last  (tx_last),
        .nack     (nack)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];
    always @(posedge clk) pix_data <= fb[pix_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected bytes of one accepted start, from the current model init state.
    task automatic push_seq();
        item_t x;
        if (!m_init_done) begin
            x = '{8'h78, 1'b1, 1'b0, 0}; q.push_back(x);
            x = '{8'h00, 1'b0, 1'b0, 0}; q.push_back(x);
            for (int i = 0; i < N_INIT; i++) begin
                x = '{rom[i], 1'b0, (i == N_INIT - 1), (i == N_INIT - 1) ? 3 : (i == 3) ? 2 : 0};
                q.push_back(x);
            end
        end
        x = '{8'h78, 1'b1, 1'b0, 0}; q.push_back(x);
        x = '{8'h40, 1'b0, 1'b0, 1}; q.push_back(x);
        for (int i = 0; i < N_PIX; i++) begin
            x = '{fb[i], 1'b0, (i == N_PIX - 1), 0};
            q.push_back(x);
        end
    endtask

    // I2C master model: ready pattern, forced stall and NACK injection.
    initial begin
        forever begin
            @(posedge clk); #1;
            nack = 1'b0;
            if (stall_cnt > 0) begin
                tx_ready = 1'b0;
                stall_cnt--;
            end else if (stall_arm && tx_valid && q.size() > 0 && q[0].tag == 1) begin
                stall_arm = 1'b0;
                stall_cnt = 4;
                tx_ready  = 1'b0;
            end else if (nack_arm && tx_valid && q.size() > 0 && q[0].tag == 2) begin
                nack_arm = 1'b0;
                nack     = 1'b1;
                tx_ready = 1'b1;
            end else begin
                tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Compare process: every handshake, stall hold and end-of-sequence event.
    always @(negedge clk) begin
        if (!rst_n) begin
            err_chk  = 1'b0;
            hold_chk = 1'b0;
        end else begin
            if (err_chk) begin
                err_chk = 1'b0;
                check("err_error", error, 1);
                check("err_busy", busy, 0);
                check("err_valid", tx_valid, 0);
                check("err_done", done, 0);
            end
            if (hold_chk) begin
                hold_chk = 1'b0;
                check("hold_valid", tx_valid, 1);
                check("hold_bits", {tx_data, tx_first, tx_last}, held);
            end
            if (tx_valid) check("valid_busy", busy, 1);
            if (nack && busy) begin
                q.delete();
                err_cnt++;
                err_chk = 1'b1;
            end else if (tx_valid && tx_ready) begin
                run_bytes++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_byte: got %0h expected none", tx_data);
                end else begin
                    it = q.pop_front();
                    check("tx_data", tx_data, it.data);
                    check("tx_first", tx_first, it.first);
                    check("tx_last", tx_last, it.last);
                    if (it.last && it.tag == 3) m_init_done = 1'b1;
                end
            end else if (tx_valid) begin
                hold_chk = 1'b1;
                held = {tx_data, tx_first, tx_last};
                if (q.size() > 0 && q[0].tag == 1) stall40++;
            end
            if (done) begin
                done_cnt++;
                check("done_q_empty", q.size(), 0);
            end
        end
    end

    task automatic do_start();
        push_seq();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_end(input int budget, input bit want_err, input string name, input int poke);
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        n  = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
            @(posedge clk); #1;
            n++;
            start = (n == poke);
        end
        start = 1'b0;
        check({name, "_timeout"}, n < budget, 1);
        check({name, "_err"}, err_cnt - e0, want_err);
        check({name, "_busy_drop"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_error"}, error, 0);
        check({name, "_valid"}, tx_valid, 0);
        check({name, "_first"}, tx_first, 0);
        check({name, "_last"}, tx_last, 0);
        check({name, "_data"}, tx_data, 8'h00);
        check({name, "_rom_addr"}, rom_addr, 0);
        check({name, "_pix_addr"}, pix_addr, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < N_PIX; i++) fb[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold start: init then frame, master always ready.
        run_bytes = 0;
        do_start();
        check("run1_first_data", tx_data, 8'h78);
        check("run1_first_flag", tx_first, 1);
        wait_end(20000, 1'b0, "run1", 0);
        check("run1_bytes", run_bytes, 1053);
        check("run1_done_cnt", done_cnt, 1);

        // Warm start: frame only, 5-cycle stall on the 0x40 control byte.
        run_bytes = 0;
        stall40   = 0;
        stall_arm = 1'b1;
        do_start();
        check("run2_first_data", tx_data, 8'h78);
        check("run2_first_flag", tx_first, 1);
        wait_end(20000, 1'b0, "run2", 0);
        check("run2_bytes", run_bytes, 1026);
        check("run2_stall40", stall40, 5);
        check("run2_done_cnt", done_cnt, 2);

        // Random ready with a start pulse while busy.
        rand_ready = 1'b1;
        run_bytes  = 0;
        do_start();
        wait_end(20000, 1'b0, "run3", 50);
        check("run3_bytes", run_bytes, 1026);
        check("run3_done_cnt", done_cnt, 3);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-frame.
        do_start();
        repeat (600) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        m_init_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_done_cnt", done_cnt, 3);

        // NACK on init command 3, coinciding with tx_ready.
        rand_ready = 1'b0;
        nack_arm   = 1'b1;
        run_bytes  = 0;
        do_start();
        wait_end(2000, 1'b1, "nack", 0);
        check("nack_bytes", run_bytes, 5);
        repeat (3) @(posedge clk);
        #1;
        check("nack_sticky", error, 1);
        check("nack_no_done", done_cnt, 3);

        // Restart reruns init and clears error.
        rand_ready = 1'b1;
        run_bytes  = 0;
        do_start();
        check("rerun_err_clear", error, 0);
        check("rerun_first_data", tx_data, 8'h78);
        wait_end(20000, 1'b0, "rerun", 0);
        check("rerun_bytes", run_bytes, 1053);
        check("rerun_done_cnt", done_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/oled_seq.md
OLED_SEQ -- requirements
Module: oled_seq

Interface
REQ-001 The block SHALL have parameter I2C_ADDR, default 7'h3C, giving the SSD1306 7-bit slave address.
REQ-002 The block SHALL have parameter N_INIT, default 25, giving the init command count.
REQ-003 The block SHALL have parameter N_PIX, default 1024, giving the frame byte count (128 columns x 8 pages).
REQ-004 Port clk: input, 1 bit, 27 MHz system clock; all logic on its rising edge.
REQ-005 Port rst_n: input, 1 bit, reset, asynchronous and active-low.
REQ-006 Port start: input, 1 bit, single-cycle refresh request.
REQ-007 Port busy: output, 1 bit, sequence in progress.
REQ-008 Port done: output, 1 bit, one-cycle pulse when a sequence ends with STOP.
REQ-009 Port error: output, 1 bit, sticky NACK flag.
REQ-010 Port rom_addr: output, 5 bits, init command ROM index; rom_data is valid combinationally.
REQ-011 Port rom_data: input, 8 bits, init command byte.
REQ-012 Port pix_addr: output, 10 bits, framebuffer read address; pix_data is valid one cycle later.
REQ-013 Port pix_data: input, 8 bits, framebuffer byte.
REQ-014 Port tx_valid: output, 1 bit, byte offered to the I2C byte master.
REQ-015 Port tx_ready: input, 1 bit, I2C master accepts the byte this cycle.
REQ-016 Port tx_data: output, 8 bits, byte to transmit.
REQ-017 Port tx_first: output, 1 bit, master issues START before this byte.
REQ-018 Port tx_last: output, 1 bit, master issues STOP after this byte.
REQ-019 Port nack: input, 1 bit, one-cycle pulse when the slave NACKs a byte.

Function
REQ-020 The FSM SHALL have states IDLE, I_ADDR, I_CTRL, I_CMD, F_ADDR, F_CTRL, F_FETCH, F_DATA, DONE, ERR.
REQ-021 A byte SHALL transfer only on a cycle with tx_valid=1 and tx_ready=1; while tx_valid=1 and tx_ready=0, tx_data, tx_first and tx_last SHALL hold stable.
REQ-022 In IDLE, start=1 SHALL go to I_ADDR if init_done=0, else to F_ADDR; busy SHALL rise on the next cycle.
REQ-023 The init transaction SHALL send {I2C_ADDR,1'b0}=8'h78 with tx_first=1, then 8'h00, then rom_data for rom_addr 0..N_INIT-1, with tx_last=1 on command N_INIT-1.
REQ-024 After the init STOP, init_done SHALL set and the FSM SHALL enter F_ADDR directly, with no done pulse between transactions.
REQ-025 The frame transaction SHALL send 8'h78 with tx_first=1, then 8'h40, then pix_data for pix_addr 0..N_PIX-1, with tx_last=1 on byte N_PIX-1.
REQ-026 F_FETCH SHALL present pix_addr for one cycle; F_DATA SHALL assert tx_valid with the registered pix_data; after acceptance pix_addr SHALL increment and the FSM SHALL return to F_FETCH. Minimum is 2 cycles per data byte.
REQ-027 Counters SHALL be sized to avoid wrap: rom_addr stops at N_INIT-1, and the 11-bit byte counter compares against N_PIX-1.
REQ-028 After the final accepted byte, DONE SHALL pulse done=1 for exactly one cycle; the FSM SHALL then return to IDLE and busy SHALL drop.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 nack=1 in any busy state SHALL force ERR next cycle: tx_valid=0, error=1, busy=0, no done pulse, and init_done unchanged if the NACK arrived during init.
REQ-031 ERR SHALL go to IDLE after one cycle; error SHALL stay set until the next accepted start, which clears it.
REQ-032 If nack and tx_ready coincide, nack SHALL take priority and the byte counter SHALL NOT advance.

Reset
REQ-033 While rst_n=0: state=IDLE, busy=0, done=0, error=0, tx_valid=0, tx_first=0, tx_last=0, tx_data=8'h00, rom_addr=0, pix_addr=0, init_done=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction immediately with no done pulse; the next start SHALL rerun init.

Verification
REQ-035 First start after reset, I2C model always ready: exactly 78,00,ROM[0..24],STOP then 78,40,FB[0..1023],STOP; one done pulse; 1053 bytes total.
REQ-036 Second start: frame transaction only (1026 bytes); first byte 8'h78 with tx_first=1.
REQ-037 tx_ready held low 5 cycles on byte 8'h40: tx_data stays 8'h40 and no byte is duplicated or skipped.
REQ-038 nack pulse on init command 3: ERR, error=1, busy=0 and no done; the next start reruns init from 8'h78 and clears error.
REQ-039 start pulses during busy are ignored; rst_n low mid-frame returns all outputs to reset values within the same cycle.
